// File: rtl/ov7670_frame_writer.sv
// OV7670 capture stage: pairs camera bytes into RGB565 pixels, reduces them to RGB444
// and emits one linear-address VRAM write per pixel, with frame/line integrity flags.
module ov7670_frame_writer #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              line_err,
    output logic              frame_err
);
    localparam int PIX_W = $clog2(H_PIXELS + 2);
    localparam logic [PIX_W-1:0]  H_CNT     = PIX_W'(H_PIXELS);
    localparam logic [9:0]        V_CNT     = 10'(V_LINES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_LINES - 1);

    typedef enum logic [1:0] {
        WAIT_VS,
        SYNC,
        CAPTURE
    } state_t;

    state_t            state_q, state_d;
    logic              vs_q, hr_q, vs_dly_q, hr_dly_q;
    logic [7:0]        d_q;
    logic              phase_q, phase_d;
    logic [6:0]        hi_q, hi_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [9:0]        line_cnt_q, line_cnt_d;
    logic              full_q, full_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;

    logic vs_rise, vs_fall, hr_rise, hr_fall, pix_done;

    assign vs_rise  = vs_q & ~vs_dly_q;
    assign vs_fall  = ~vs_q & vs_dly_q;
    assign hr_rise  = hr_q & ~hr_dly_q;
    assign hr_fall  = ~hr_q & hr_dly_q;
    assign pix_done = (state_q == CAPTURE) && hr_q && phase_q;

    always_comb begin
        state_d       = state_q;
        phase_d       = 1'b0;
        hi_d          = hi_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        full_d        = full_q;
        wr_d          = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        line_err_d    = 1'b0;
        frame_err_d   = frame_err_q;

        // wr_addr names the pixel being written, so it advances the cycle after the strobe
        if (wr_q) begin
            if (wr_addr_q == LAST_ADDR) begin
                full_d = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        case (state_q)
            WAIT_VS: begin
                if (vs_q) begin
                    state_d = SYNC;
                end
            end

            SYNC: begin
                if (vs_fall) begin
                    state_d     = CAPTURE;
                    wr_addr_d   = '0;
                    full_d      = 1'b0;
                    pix_cnt_d   = '0;
                    line_cnt_d  = '0;
                    frame_err_d = 1'b0;
                end
            end

            CAPTURE: begin
                phase_d = hr_q ? ~phase_q : 1'b0;
                // Only the high-byte bits that survive the RGB444 reduction are kept
                if (hr_q && !phase_q) begin
                    hi_d = {d_q[7:4], d_q[2:0]};
                end
                if (hr_rise) begin
                    pix_cnt_d = '0;
                end
                if (pix_done) begin
                    if (pix_cnt_q != '1) begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                    if (full_q) begin
                        frame_err_d = 1'b1;
                    end else begin
                        wr_d      = 1'b1;
                        wr_data_d = {hi_q, d_q[7], d_q[4:1]};
                    end
                end
                if (vs_rise) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 1'b1;
                    if (line_cnt_q != V_CNT) begin
                        frame_err_d = 1'b1;
                    end
                    state_d = SYNC;
                end else if (hr_fall) begin
                    if (pix_cnt_q != H_CNT) begin
                        line_err_d  = 1'b1;
                        frame_err_d = 1'b1;
                    end
                    if (line_cnt_q != '1) begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_VS;
            vs_q          <= 1'b0;
            hr_q          <= 1'b0;
            vs_dly_q      <= 1'b0;
            hr_dly_q      <= 1'b0;
            d_q           <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            full_q        <= 1'b0;
            wr_q          <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vsync;
            hr_q          <= href;
            vs_dly_q      <= vs_q;
            hr_dly_q      <= hr_q;
            d_q           <= d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            full_q        <= full_d;
            wr_q          <= wr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign wr          = wr_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Bench for ov7670_frame_writer: drives camera frames and compares writes and frame
// status against a pixel-level reference model of the capture rules.
module tb_ov7670_frame_writer;

   localparam int H     = 8;
   localparam int V     = 6;
   localparam int AW    = 6;
   localparam int TOTAL = H * V;

   typedef struct {
      int addr;
      int data;
   } wr_exp_t;

   typedef struct {
      int err;
      int count;
      int lerr;
   } fr_exp_t;

   logic          pclk  = 1'b0;
   logic          rst   = 1'b1;
   logic          vsync = 1'b0;
   logic          href  = 1'b0;
   logic [7:0]    d     = 8'h00;
   logic          wr;
   logic [AW-1:0] wr_addr;
   logic [11:0]   wr_data;
   logic          frame_done;
   logic [7:0]    frame_count;
   logic          line_err;
   logic          frame_err;

   int      errors      = 0;
   int      checks      = 0;
   bit      monOn       = 1'b1;
   bit      prevWr      = 1'b0;
   int      lineErrSeen = 0;
   int      expCount    = 0;
   int      pattern     = 0;
   int      lineLen[$];
   wr_exp_t expWr[$];
   fr_exp_t expFr[$];

   ov7670_frame_writer #(
      .H_PIXELS(H),
      .V_LINES (V),
      .ADDR_W  (AW)
   ) dut (
      .pclk       (pclk),
      .rst        (rst),
      .vsync      (vsync),
      .href       (href),
      .d          (d),
      .wr         (wr),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_count(frame_count),
      .line_err   (line_err),
      .frame_err  (frame_err)
   );

   // Free-running camera pixel clock
   always #5 pclk = ~pclk;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // RGB565 -> RGB444 by dropping the low bits of each colour field
   function automatic int toRgb444(input int p);
      int r5, g6, b5;
      r5 = p / 2048;
      g6 = (p / 32) % 64;
      b5 = p % 32;
      return (r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2);
   endfunction

   task automatic checkAllZero(input string prefix);
      checkOutput({prefix, "_wr"},          int'(wr),          0);
      checkOutput({prefix, "_wr_addr"},     int'(wr_addr),     0);
      checkOutput({prefix, "_wr_data"},     int'(wr_data),     0);
      checkOutput({prefix, "_frame_done"},  int'(frame_done),  0);
      checkOutput({prefix, "_frame_count"}, int'(frame_count), 0);
      checkOutput({prefix, "_line_err"},    int'(line_err),    0);
      checkOutput({prefix, "_frame_err"},   int'(frame_err),   0);
   endtask

   // One frame: vsync low, the lines in lineLen, then vsync high to close it.
   // When capture is set the model predicts every write and the frame status.
   task automatic applyStimulus(input bit capture);
      int   addr = 0;
      bit   ovf  = 1'b0;
      int   lerr = 0;
      int   np, p;
      logic [7:0] b[];
      @(negedge pclk) vsync = 1'b0;
      repeat (2) @(negedge pclk);
      if (capture) checkOutput("frame_err_clear", int'(frame_err), 0);
      foreach (lineLen[l]) begin
         b = new[lineLen[l]];
         for (int i = 0; i < lineLen[l]; i++)
            b[i] = (pattern != 0) ? ((i % 2 == 1) ? 8'h1F : 8'hF8) : 8'($urandom);
         if (capture) begin
            np = lineLen[l] / 2;
            if (np != H) lerr++;
            for (int k = 0; k < np; k++) begin
               p = int'(b[2*k]) * 256 + int'(b[2*k+1]);
               if (addr < TOTAL) begin
                  expWr.push_back('{addr: addr, data: toRgb444(p)});
                  addr++;
               end else begin
                  ovf = 1'b1;
               end
            end
         end
         for (int i = 0; i < lineLen[l]; i++) begin
            @(negedge pclk);
            href = 1'b1;
            d    = b[i];
         end
         @(negedge pclk);
         href = 1'b0;
         d    = 8'($urandom);
         repeat ($urandom_range(1, 4)) @(negedge pclk);
      end
      if (capture) begin
         expCount = (expCount + 1) % 256;
         expFr.push_back('{err: (ovf || lerr > 0 || lineLen.size() != V) ? 1 : 0,
                           count: expCount, lerr: lerr});
      end
      @(negedge pclk) vsync = 1'b1;
      repeat (6) @(negedge pclk);
   endtask

   task automatic setLines(input int n, input int bytes);
      lineLen.delete();
      for (int i = 0; i < n; i++) lineLen.push_back(bytes);
   endtask

   // Output monitor, sampled on the falling edge away from register updates
   always @(negedge pclk) begin : monitor
      wr_exp_t we;
      fr_exp_t fe;
      if (!rst && monOn) begin
         if (wr) begin
            checkOutput("wr_spacing", int'(prevWr), 0);
            if (expWr.size() == 0) begin
               checkOutput("wr_unexpected", expWr.size(), 1);
            end else begin
               we = expWr.pop_front();
               checkOutput("wr_addr", int'(wr_addr), we.addr);
               checkOutput("wr_data", int'(wr_data), we.data);
            end
         end
         if (line_err) lineErrSeen++;
         if (frame_done) begin
            if (expFr.size() == 0) begin
               checkOutput("frame_unexpected", expFr.size(), 1);
            end else begin
               fe = expFr.pop_front();
               checkOutput("frame_count", int'(frame_count), fe.count);
               checkOutput("frame_err",   int'(frame_err),   fe.err);
               checkOutput("line_err_cnt", lineErrSeen,      fe.lerr);
               checkOutput("wr_left_in_frame", expWr.size(), 0);
            end
            lineErrSeen = 0;
         end
      end
      prevWr = wr;
   end

   initial begin : watchdog
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      repeat (3) @(negedge pclk);
      checkAllZero("reset");

      // Release reset mid-frame: vsync low, href active; nothing may be written
      href = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom);
         if (i == 3) rst = 1'b0;
         @(negedge pclk);
      end
      href = 1'b0;
      repeat (3) @(negedge pclk);
      href = 1'b1;
      for (int i = 0; i < 2 * H; i++) begin
         d = 8'($urandom);
         @(negedge pclk);
      end
      href = 1'b0;
      repeat (3) @(negedge pclk);
      vsync = 1'b1;
      repeat (6) @(negedge pclk);

      $display("[TB] nominal frame");
      pattern = 1;
      setLines(V, 2 * H);
      applyStimulus(1'b1);
      pattern = 0;

      $display("[TB] short line 5, then a clean frame");
      setLines(V, 2 * H);
      lineLen[4] = 2 * (H - 2);
      applyStimulus(1'b1);
      setLines(V, 2 * H);
      applyStimulus(1'b1);

      $display("[TB] overflow frame");
      setLines(V + 1, 2 * H);
      applyStimulus(1'b1);

      $display("[TB] odd trailing byte");
      setLines(V, 2 * H);
      lineLen[1] = 2 * H + 1;
      applyStimulus(1'b1);

      $display("[TB] random frames");
      for (int f = 0; f < 8; f++) begin
         lineLen.delete();
         for (int l = 0; l < int'($urandom_range(V - 1, V + 1)); l++) begin
            case ($urandom_range(0, 4))
               0:       lineLen.push_back(2 * H - 2);
               1:       lineLen.push_back(2 * H + 1);
               2:       lineLen.push_back(2 * H + 3);
               default: lineLen.push_back(2 * H);
            endcase
         end
         applyStimulus(1'b1);
      end

      $display("[TB] frame counter wrap");
      lineLen.delete();
      for (int f = 0; f < 260; f++) applyStimulus(1'b1);
      checkOutput("frame_count_wrap", int'(frame_count), expCount);

      $display("[TB] reset asserted mid-line");
      monOn = 1'b0;
      @(negedge pclk) vsync = 1'b0;
      repeat (3) @(negedge pclk);
      href = 1'b1;
      for (int i = 0; i < 5; i++) begin
         d = (i % 2 == 1) ? 8'h1F : 8'hF8;
         @(negedge pclk);
      end
      @(posedge pclk);
      #2 rst = 1'b1;
      #1 checkAllZero("midreset");
      repeat (3) @(negedge pclk);
      rst         = 1'b0;
      lineErrSeen = 0;
      expCount    = 0;
      expWr.delete();
      expFr.delete();
      monOn       = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         @(negedge pclk);
      end
      href = 1'b0;
      repeat (3) @(negedge pclk);
      vsync = 1'b1;
      repeat (6) @(negedge pclk);
      setLines(V, 2 * H);
      applyStimulus(1'b1);

      repeat (10) @(negedge pclk);
      checkOutput("wr_queue_empty",    expWr.size(), 0);
      checkOutput("frame_queue_empty", expFr.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ov7670_frame_writer.md
# ov7670_frame_writer

Camera-side capture stage in the pixel clock domain. Samples the OV7670 byte stream (vsync/href/8-bit data), pairs bytes into RGB565 pixels, and reduces them to RGB444. Emits one VRAM write per pixel with a linear frame address. Feeds the write side of the camera-to-VRAM path and reports frame and line integrity for debug LEDs.

## Interface
Parameters:
- H_PIXELS, 320: active pixels per line.
- V_LINES, 240: active lines per frame.
- ADDR_W, 17: write address width; H_PIXELS*V_LINES must be ≤ 2^ADDR_W.

Ports (one clock; reset asynchronous, active-high):
- pclk  in  1  camera pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- vsync  in  1  camera vsync; high = vertical blanking.
- href  in  1  camera href; high = active bytes on d.
- d  in  8  camera data byte.
- wr  out  1  VRAM write strobe, one cycle per pixel.
- wr_addr  out  ADDR_W  linear pixel address, row-major from 0.
- wr_data  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- frame_count  out  8  completed frames, wraps 255→0.
- line_err  out  1  one-cycle pulse when a line ends with pixel count ≠ H_PIXELS.
- frame_err  out  1  sticky per frame: set on line_err, line count ≠ V_LINES, or address overflow; cleared at next frame start.

## Operation
- Input register stage: vsync, href and d are registered once (vs_q, hr_q, d_q). All decisions use the registered copies. Edges are detected against a second delayed copy of vs_q/hr_q.
- FSM states:
  - WAIT_VS: entered on reset. Waits for vs_q=1, which guarantees capture starts on a whole frame. Then go to SYNC.
  - SYNC: waits for vs_q falling. On the fall: wr_addr←0, line/pixel counters←0, frame_err←0. Then go to CAPTURE.
  - CAPTURE: active capture. On vs_q rising:
    - pulse frame_done;
    - frame_count+1;
    - if line count ≠ V_LINES, set frame_err (visible on the same cycle as frame_done);
    - go to SYNC.
- Byte pairing (CAPTURE only): a phase bit clears whenever hr_q=0 and toggles on each hr_q=1 cycle.
  - Phase 0: byte is stored as the high byte.
  - Phase 1: completes pixel p={hi,d_q}.
  - wr_data = {p[15:12], p[10:7], p[4:1]}.
- Write: one wr pulse per completed pixel. wr_addr is the address of that pixel and increments by 1 after each write.
  - Overflow: when wr_addr would reach H_PIXELS*V_LINES, writes are suppressed (wr stays 0), the address holds, and frame_err is set.
- Line accounting: per-line pixel counter clears on hr_q rising. On hr_q falling:
  - if count ≠ H_PIXELS, pulse line_err and set frame_err;
  - line counter saturates at 2^10−1.
- An odd trailing byte at the end of a line is discarded. It counts toward no pixel.
- href activity outside CAPTURE is ignored: no writes, no errors.
- vsync rising while hr_q=1 ends the frame normally. The partial line is not evaluated for line_err.

## Timing
- Reset values: wr=0, wr_addr=0, wr_data=0, frame_done=0, frame_count=0, line_err=0, frame_err=0, FSM=WAIT_VS, phase=0.
- Reset asserted mid-frame clears everything immediately. After release the block resynchronises via WAIT_VS, so a partial frame is never written.
- Write latency: second byte of a pixel present on d at edge N; registered at N; wr/wr_addr/wr_data registered outputs valid after edge N+1, for exactly one cycle.
- Back-to-back pixels produce wr every other cycle. wr is never high on consecutive cycles.
- frame_done and line_err are registered and asserted the cycle after the registered edge is detected, i.e. 2 cycles after the pin edge.
- frame_count updates on the same cycle as the frame_done pulse.

## Test plan
- Nominal frame: 320×240 frame of bytes {0xF8,0x1F} from reset (vsync high first) → 76800 wr pulses, addresses 0..76799 in order, wr_data=0xF0F, one frame_done, frame_count=1, frame_err=0, no line_err.
- Mid-frame start: release reset with vsync low and href active → no writes until a full vsync high→low cycle; next frame starts at wr_addr=0.
- Short line: line 5 has 318 pixels → single line_err after that href fall; frame_err=1 at frame_done; following frame with correct lines → frame_err clears at its vsync fall.
- Overflow: frame with 241 lines of 320 → exactly 76800 writes, last address 76799, frame_err=1.
- Odd byte: line of 641 bytes → 320 writes, extra byte dropped; next line pairs correctly starting at its first byte.
- Wrap/reset: 256 frames → frame_count wraps to 0; assert rst mid-line → all outputs 0 within the same cycle, FSM back to WAIT_VS.
